// File: rtl/uart_dec_tx.sv
// uart_dec_tx: sends a latched byte as three ASCII decimal digits over an 8N1 UART line.
// Define UART_DEC_TX_CRLF_EN to append CR LF to every message.
module uart_dec_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic [7:0] value,
    input  logic       run,
    output logic       tx_data_bit,
    output logic       tx_transmitting,
    output logic       tx_done
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
`ifdef UART_DEC_TX_CRLF_EN
    localparam logic [2:0] CHAR_LAST = 3'd4;
`else
    localparam logic [2:0] CHAR_LAST = 3'd2;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [2:0]        char_idx;
    logic [7:0]        value_q;
    logic [7:0]        cur_char;
    logic [2:0]        bit_nxt;

    function automatic logic [7:0] dec_char(input logic [7:0] v, input logic [2:0] idx);
        logic [7:0] hun;
        logic [7:0] ten;
        logic [7:0] one;
        hun = v / 8'd100;
        ten = (v / 8'd10) % 8'd10;
        one = v % 8'd10;
        case (idx)
            3'd0:    dec_char = 8'h30 + hun;
            3'd1:    dec_char = 8'h30 + ten;
`ifdef UART_DEC_TX_CRLF_EN
            3'd3:    dec_char = 8'h0D;
            3'd4:    dec_char = 8'h0A;
`endif
            default: dec_char = 8'h30 + one;
        endcase
    endfunction

    // Character is derived from the latched byte, so it is stable before START begins.
    assign cur_char = dec_char(value_q, char_idx);
    assign bit_nxt  = bit_idx + 3'd1;

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state           <= IDLE;
            tx_data_bit     <= 1'b1;
            tx_transmitting <= 1'b0;
            tx_done         <= 1'b0;
            baud_cnt        <= '0;
            bit_idx         <= '0;
            char_idx        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        value_q         <= value;
                        char_idx        <= '0;
                        baud_cnt        <= '0;
                        tx_data_bit     <= 1'b0;
                        tx_transmitting <= 1'b1;
                        state           <= START;
                    end
                end
                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt    <= '0;
                        bit_idx     <= '0;
                        tx_data_bit <= cur_char[0];
                        state       <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_data_bit <= 1'b1;
                            state       <= STOP;
                        end else begin
                            bit_idx     <= bit_nxt;
                            tx_data_bit <= cur_char[bit_nxt];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (char_idx == CHAR_LAST) begin
                            tx_done         <= 1'b1;
                            tx_transmitting <= 1'b0;
                            state           <= DONE;
                        end else begin
                            char_idx    <= char_idx + 3'd1;
                            tx_data_bit <= 1'b0;
                            state       <= START;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                DONE: begin
                    tx_done <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_dec_tx.sv
// tb_uart_dec_tx: vector table plus corner-case sequences, bytes checked by a bit-centre UART decoder.
// Expected message length follows UART_DEC_TX_CRLF_EN the same way the design does.
module tb_uart_dec_tx;
    localparam int CPB = 4;
`ifdef UART_DEC_TX_CRLF_EN
    localparam int NCH = 5;
`else
    localparam int NCH = 3;
`endif
    localparam int MSG_CYC = NCH * 10 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] value;
    logic       run;
    logic       tx_data_bit;
    logic       tx_transmitting;
    logic       tx_done;

    always #5 clk = ~clk;

    uart_dec_tx #(.CLKS_PER_BIT(CPB)) dut (
        .CLOCK_50       (clk),
        .rst            (rst),
        .value          (value),
        .run            (run),
        .tx_data_bit    (tx_data_bit),
        .tx_transmitting(tx_transmitting),
        .tx_done        (tx_done)
    );

    typedef struct {
        logic [7:0] v;
        logic [7:0] c0;
        logic [7:0] c1;
        logic [7:0] c2;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_msg(input vec_t e);
        exp_q.push_back(e.c0);
        exp_q.push_back(e.c1);
        exp_q.push_back(e.c2);
`ifdef UART_DEC_TX_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic start_msg(input logic [7:0] v);
        @(posedge clk); #1;
        value = v;
        run   = 1'b1;
        @(posedge clk); #1;
        run   = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int len);
        int n;
        n   = 0;
        len = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (tx_done) break;
            if (tx_transmitting) len++;
        end
        check({name, "_done_seen"}, tx_done, 1);
    endtask

    task automatic check_quiet(input string name, input int cycles);
        int bad;
        bad = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (tx_transmitting || !tx_data_bit || tx_done) bad++;
        end
        check(name, bad, 0);
    endtask

    // Receiver: start detected on first low sample, data sampled at bit centres.
    initial begin : monitor
        int         mcnt;
        logic       busy;
        logic [7:0] mbyte;
        logic [7:0] e;
        busy  = 1'b0;
        mcnt  = 0;
        mbyte = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 1'b0;
            end else if (!busy) begin
                if (tx_data_bit == 1'b0) begin
                    busy = 1'b1;
                    mcnt = 1;
                end
            end else begin
                if (mcnt >= 6 && mcnt <= 34 && (mcnt % 4) == 2)
                    mbyte = {tx_data_bit, mbyte[7:1]};
                if (mcnt == 38) begin
                    busy = 1'b0;
                    check("stop_bit", tx_data_bit, 1);
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL byte_unexpected: got %02h, no byte expected", mbyte);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", mbyte, e);
                    end
                end
                mcnt++;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got no finish, expected finish within budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int   len;
        vec_t v;
        vecs[0] = '{8'd0,   8'h30, 8'h30, 8'h30};
        vecs[1] = '{8'd255, 8'h32, 8'h35, 8'h35};
        vecs[2] = '{8'd7,   8'h30, 8'h30, 8'h37};
        vecs[3] = '{8'd45,  8'h30, 8'h34, 8'h35};
        vecs[4] = '{8'd10,  8'h30, 8'h31, 8'h30};
        vecs[5] = '{8'd199, 8'h31, 8'h39, 8'h39};

        rst   = 1'b1;
        run   = 1'b0;
        value = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_line", tx_data_bit, 1);
        check("reset_busy", tx_transmitting, 0);
        check("reset_done", tx_done, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            push_msg(vecs[i]);
            start_msg(vecs[i].v);
            @(negedge clk);
            check($sformatf("v%0d_start_line", i), tx_data_bit, 0);
            check($sformatf("v%0d_start_busy", i), tx_transmitting, 1);
            wait_done($sformatf("v%0d", i), 2 * MSG_CYC, len);
            check($sformatf("v%0d_msg_len", i), len, MSG_CYC - 1);
            check($sformatf("v%0d_done_line", i), tx_data_bit, 1);
            check($sformatf("v%0d_done_busy", i), tx_transmitting, 0);
            @(negedge clk);
            check($sformatf("v%0d_done_single", i), tx_done, 0);
            check($sformatf("v%0d_queue_drained", i), exp_q.size(), 0);
        end

        // Run pulse while busy and value changes mid-message are both ignored.
        v = '{8'd123, 8'h31, 8'h32, 8'h33};
        push_msg(v);
        start_msg(8'd123);
        repeat (48) @(negedge clk);
        value = 8'd45;
        run   = 1'b1;
        @(negedge clk);
        run   = 1'b0;
        repeat (30) @(negedge clk);
        value = 8'd200;
        wait_done("busy", 2 * MSG_CYC, len);
        @(negedge clk);
        check("busy_done_single", tx_done, 0);
        check("busy_queue_drained", exp_q.size(), 0);
        check_quiet("busy_no_requeue", 2 * MSG_CYC);

        // Reset during DATA of the second character.
        push_msg(v);
        start_msg(8'd123);
        repeat (55) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_line", tx_data_bit, 1);
        check("midrst_busy", tx_transmitting, 0);
        check("midrst_done", tx_done, 0);
        exp_q.delete();
        check_quiet("midrst_quiet", 60);
        v = '{8'd9, 8'h30, 8'h30, 8'h39};
        push_msg(v);
        start_msg(8'd9);
        wait_done("after_rst", 2 * MSG_CYC, len);
        check("after_rst_len", len, MSG_CYC);
        @(negedge clk);
        check("after_rst_queue", exp_q.size(), 0);

        // Held run: DONE cycle plus one IDLE cycle between messages.
        v = '{8'd100, 8'h31, 8'h30, 8'h30};
        push_msg(v);
        push_msg(v);
        @(posedge clk); #1;
        value = 8'd100;
        run   = 1'b1;
        wait_done("held1", 2 * MSG_CYC, len);
        check("held1_len", len, MSG_CYC);
        check("held_gap0_line", tx_data_bit, 1);
        @(negedge clk);
        check("held_gap1_line", tx_data_bit, 1);
        check("held_gap1_busy", tx_transmitting, 0);
        check("held_gap1_done", tx_done, 0);
        @(negedge clk);
        check("held_restart_line", tx_data_bit, 0);
        check("held_restart_busy", tx_transmitting, 1);
        run = 1'b0;
        wait_done("held2", 2 * MSG_CYC, len);
        check("held2_len", len, MSG_CYC - 1);
        @(negedge clk);
        check("held_queue_drained", exp_q.size(), 0);
        check_quiet("held_stops", 60);

        // Reset and run in the same cycle: reset wins.
        @(posedge clk); #1;
        rst   = 1'b1;
        run   = 1'b1;
        value = 8'd55;
        @(posedge clk); #1;
        rst   = 1'b0;
        run   = 1'b0;
        check_quiet("rst_run_quiet", 60);
        check("rst_run_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_dec_tx.md
# uart_dec_tx

Serial transmitter that sends an 8-bit value as three ASCII decimal digits over a UART line (8N1, LSB first), optionally followed by CR LF. It is the serial counterpart of the receive-and-display path: the receiver delivers a byte that the 7-segment decoder shows in decimal, and this block sends such a byte back to the host as decimal text. It sits beside the UART receiver in the top-level module and shares the CLOCK_50 domain with it.

## Interface

- CLKS_PER_BIT, default 434: clock cycles per UART bit (50 MHz / 115200 baud). Legal range is 2 or more.
- CLOCK_50 (input, 1): single system clock. All logic is rising-edge.
- rst (input, 1): synchronous, active-high reset.
- value (input, 8): unsigned byte to send, range 0..255.
- run (input, 1): start request. Sampled on every clock edge.
- tx_data_bit (output, 1): serial line. Idles high.
- tx_transmitting (output, 1): high from the first start-bit cycle through the last stop-bit cycle.
- tx_done (output, 1): one-cycle pulse when a complete message has finished.

## Operation

- **States:** IDLE, START, DATA, STOP, DONE.
- **Reset values:** tx_data_bit=1, tx_transmitting=0, tx_done=0, state=IDLE.
- **Reset priority:** rst is evaluated first on every edge, including mid-message. On reset the line returns high on the next cycle and the message is abandoned with no tx_done.
- **IDLE:**
  - On run=1, latch value into an internal register, load character index 0, and go to START. Later changes on value are ignored.
  - While run=0, stay in IDLE.
- **Digit conversion:**
  - From the latched byte v: H = v/100, T = (v/10)%10, O = v%10.
  - Each character is 8'h30 + digit.
  - Leading zeros are always sent (7 sends "007").
  - The conversion method is free, but a character must be valid before its START state begins.
- **Character sequence:** H, T, O, then CR (8'h0D) and LF (8'h0A) when configured.
- **START:** drive 0 for CLKS_PER_BIT cycles.
- **DATA:** drive bits 0..7 of the current character, LSB first, each for CLKS_PER_BIT cycles. A bit counter runs 0..7.
- **STOP:** drive 1 for CLKS_PER_BIT cycles.
  - If more characters remain, increment the index and go directly to START, with no idle gap between characters.
  - Otherwise go to DONE.
- **DONE:** lasts one cycle.
  - tx_done=1, tx_transmitting=0, tx_data_bit=1.
  - Then go to IDLE.
- **run outside IDLE:** ignored in START, DATA, STOP and DONE. It is not queued. A new message starts only when run is sampled in IDLE.
- **Holding run:** keeping run high continuously sends messages back to back. Between messages there is the DONE cycle plus one IDLE cycle.

## Timing

- **Start latency:** run is sampled at edge 0. tx_data_bit=0 and tx_transmitting=1 from the cycle after edge 0.
- **Bit length:** every bit lasts exactly CLKS_PER_BIT cycles. The baud counter runs 0..CLKS_PER_BIT-1 and is cleared on every bit transition.
- **Character length:** 10*CLKS_PER_BIT cycles.
- **Message length:** N*10*CLKS_PER_BIT cycles of tx_transmitting=1, where N=5 with CR LF and N=3 without.
- **tx_done:** asserted in the single cycle immediately after the final stop bit period.
- **Next start:** a run sampled in the IDLE cycle following DONE yields a new start bit one cycle later.
- **Counter widths:**
  - Baud counter: $clog2(CLKS_PER_BIT) bits.
  - Bit counter: 3 bits.
  - Character index: 3 bits.
  - No counter may wrap before its terminal compare.

## Configuration

- **Macro:** UART_DEC_TX_CRLF_EN.
- **Defined:** each message is 5 characters (H, T, O, CR, LF), N=5.
- **Undefined:** each message is 3 characters (H, T, O), N=3. No CR/LF logic or index values beyond 2 exist in the build.

## Test plan

All scenarios use CLKS_PER_BIT=4 and a bench UART decoder that samples at bit centres.

- **Zero value:** run=1 for one cycle with value=0, macro defined.
  - Bytes 0x30 0x30 0x30 0x0D 0x0A.
  - tx_transmitting high for exactly 200 cycles, then one tx_done pulse.
- **Maximum value and leading zeros:** value=255, then value=7, macro undefined.
  - Bytes 0x32 0x35 0x35, then 0x30 0x30 0x37.
  - Each message is 120 cycles, and tx_done pulses once per message.
- **Busy and latch behaviour:** start with value=123, pulse run again at cycle 50 with value=45, and change value mid-message.
  - Only 0x31 0x32 0x33 (plus CR LF) is sent, with one tx_done.
- **Reset mid-message:** assert rst for one cycle during the DATA state of the second character.
  - Next cycle: tx_data_bit=1, tx_transmitting=0, no tx_done.
  - A subsequent run with value=9 sends a clean "009".
- **Held run:** hold run high over two messages with value=100.
  - Two identical "100" messages.
  - Exactly 2 cycles with tx_data_bit=1 between the last stop bit and the next start bit.
- **Reset and run together:** assert rst and run in the same cycle.
  - Reset wins: line stays high and no message is sent.
